// File: rtl/wm_entry_ctrl.sv
// Front-panel entry controller: dial a signed BCD balance, pick a wash mode,
// then hand both to the wash sequencer with a one-cycle go pulse.
module wm_entry_ctrl #(
  parameter int DIGITS = 3,
  parameter int TICK   = 66000000,
  parameter int MODES  = 4,
  localparam int MW    = (MODES > 1) ? $clog2(MODES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    on,
  input  logic [DIGITS-1:0]       inc,
  input  logic                    sign,
  input  logic                    ok_p,
  input  logic                    sel_p,
  input  logic                    back_p,
  output logic [4*(DIGITS+1)-1:0] disp,
  output logic [DIGITS*4-1:0]     bal,
  output logic [MW-1:0]           mode,
  output logic [1:0]              st,
  output logic [2:0]              st_light,
  output logic                    go
);

  localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK - 1);
  localparam logic [MW-1:0] MODE_MAX = MW'(MODES - 1);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'b00,
    ST_MODE  = 2'b01,
    ST_READY = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  state_e                  st_q,    st_d;
  logic [DIGITS-1:0][3:0]  digit_q, digit_d;
  logic [DIGITS-1:0][3:0]  bal_q,   bal_d;
  logic                    neg_q,   neg_d;
  logic [MW-1:0]           mode_q,  mode_d;
  logic [CW-1:0]           cnt_q,   cnt_d;
  logic                    go_q,    go_d;
  logic                    tick;

  assign tick = (st_q == ST_ENTRY) && (cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statements can leave one unassigned and infer a latch.
    st_d    = st_q;
    digit_d = digit_q;
    bal_d   = bal_q;
    neg_d   = neg_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    go_d    = 1'b0;

    if (st_q == ST_BAD) begin
      // Illegal encoding recovers to ENTRY even while disabled.
      st_d  = ST_ENTRY;
      cnt_d = '0;
    end else if (on) begin
      case (st_q)
        ST_ENTRY: begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (ok_p) begin
            // A confirm always consumes the cycle; any coincident tick is lost.
            if (inc == '0 && !sign && !neg_q) begin
              st_d   = ST_MODE;
              mode_d = '0;
              bal_d  = digit_q;
              cnt_d  = '0;
            end else begin
              digit_d = '0;
              neg_d   = 1'b0;
            end
          end else if (tick) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (inc[i]) digit_d[i] = (digit_q[i] == 4'd9) ? 4'd0 : digit_q[i] + 4'd1;
            end
            if (sign) neg_d = ~neg_q;
          end
        end
        ST_MODE: begin
          cnt_d = '0;
          if (back_p) begin
            st_d    = ST_ENTRY;
            digit_d = bal_q;
            neg_d   = 1'b0;
          end else if (ok_p) begin
            st_d = ST_READY;
            go_d = 1'b1;
          end else if (sel_p) begin
            mode_d = (mode_q == MODE_MAX) ? '0 : mode_q + 1'b1;
          end
        end
        ST_READY: begin
          cnt_d = '0;
          if (back_p) st_d = ST_MODE;
        end
        default: begin
          st_d  = ST_ENTRY;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block and
    // only takes effect on an edge; state updates use non-blocking assignment.
    if (!rst) begin
      st_q    <= ST_ENTRY;
      digit_q <= '0;
      bal_q   <= '0;
      neg_q   <= 1'b0;
      mode_q  <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      digit_q <= digit_d;
      bal_q   <= bal_d;
      neg_q   <= neg_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
    end
  end

  // ENTRY shows the dial with its sign; MODE and READY show the chosen mode.
  always_comb begin
    disp = '0;
    case (st_q)
      ST_ENTRY: begin
        disp[4*DIGITS-1:0]      = digit_q;
        disp[4*DIGITS +: 4]     = neg_q ? 4'd10 : 4'd0;
      end
      ST_MODE, ST_READY: disp[MW-1:0] = mode_q;
      default: disp = '0;
    endcase
  end

  always_comb begin
    case (st_q)
      ST_ENTRY: st_light = 3'b001;
      ST_MODE:  st_light = 3'b011;
      ST_READY: st_light = 3'b111;
      default:  st_light = 3'b000;
    endcase
  end

  assign st   = st_q;
  assign bal  = bal_q;
  assign mode = mode_q;
  assign go   = go_q;

endmodule
